// File: rtl/clarvi_regfile_sequencer.sv
// clarvi_regfile_sequencer
//   Arbitrates between a core and a debug requester and turns each accepted
//   64-bit register access into four 16-bit register-file part accesses.
//   Parts go out LSB first (part 0 = bits [15:0]), then a one-cycle response.
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   core_req_* / dbg_req_*   valid/ready request channels (write, reg, wdata)
//   resp_valid/source/rdata  one-cycle completion pulse, source 1 = debug
//   busy                     high whenever not IDLE
//   rf_*                     16-bit wide register-file port; rf_data_out is
//                            combinational read data for the fetch index/part
module clarvi_regfile_sequencer #(
    parameter bit DBG_PRIORITY = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic        core_req_write,
    input  logic [4:0]  core_req_reg,
    input  logic [63:0] core_req_wdata,
    input  logic        dbg_req_valid,
    output logic        dbg_req_ready,
    input  logic        dbg_req_write,
    input  logic [4:0]  dbg_req_reg,
    input  logic [63:0] dbg_req_wdata,
    output logic        resp_valid,
    output logic        resp_source,
    output logic [63:0] resp_rdata,
    output logic        busy,
    output logic [4:0]  rf_fetch_register,
    output logic [4:0]  rf_write_register,
    output logic [1:0]  rf_fetch_part,
    output logic [1:0]  rf_write_part,
    output logic [15:0] rf_data_in,
    output logic        rf_write_enable,
    input  logic [15:0] rf_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic [1:0]  part;
    logic        last_dbg;    // 1 = debug was granted most recently
    logic        grant_dbg;
    logic        accept;
    logic        wr_q;
    logic        src_q;
    logic [4:0]  reg_q;
    logic [63:0] wdata_q;
    logic [63:0] rbuf;
    logic [5:0]  bit_base;
    logic        in_access;

    // Grant: a lone requester wins; on contention either debug (priority mode)
    // or whichever side did not win last time.
    always_comb begin
        grant_dbg = dbg_req_valid;
        if (core_req_valid && dbg_req_valid)
            grant_dbg = DBG_PRIORITY ? 1'b1 : !last_dbg;
    end

    always_comb begin
        core_req_ready = (state == IDLE) && !reset && core_req_valid && !grant_dbg;
        dbg_req_ready  = (state == IDLE) && !reset && dbg_req_valid && grant_dbg;
        accept         = core_req_ready || dbg_req_ready;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  if (part == 2'd3) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bit_base  = {part, 4'b0000};
    assign in_access = (state == ACCESS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            part     <= 2'd0;
            last_dbg <= 1'b1;
            wr_q     <= 1'b0;
            src_q    <= 1'b0;
            reg_q    <= 5'd0;
            wdata_q  <= 64'd0;
            rbuf     <= 64'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_dbg <= grant_dbg;
                src_q    <= grant_dbg;
                wr_q     <= grant_dbg ? dbg_req_write : core_req_write;
                reg_q    <= grant_dbg ? dbg_req_reg   : core_req_reg;
                wdata_q  <= grant_dbg ? dbg_req_wdata : core_req_wdata;
                rbuf     <= 64'd0;
            end
            if (in_access) begin
                // Counter wraps 3 -> 0 as ACCESS exits, so it idles at 0.
                part <= part + 2'd1;
                if (!wr_q)
                    rbuf[bit_base +: 16] <= rf_data_out;
            end
        end
    end

    always_comb begin
        rf_fetch_register = in_access ? reg_q : 5'd0;
        rf_write_register = in_access ? reg_q : 5'd0;
        rf_fetch_part     = in_access ? part : 2'd0;
        rf_write_part     = in_access ? part : 2'd0;
        rf_data_in        = (in_access && wr_q) ? wdata_q[bit_base +: 16] : 16'd0;
        // Gated by reset so an abort stops the strobe in the very cycle it hits.
        rf_write_enable   = in_access && wr_q && (reg_q != 5'd0) && !reset;
        resp_valid        = (state == RESP);
        resp_source       = resp_valid && src_q;
        // x0 always reads as zero whatever the register file returns.
        resp_rdata        = (resp_valid && !wr_q && (reg_q != 5'd0)) ? rbuf : 64'd0;
        busy              = (state != IDLE);
    end

endmodule

// File: tb/tb_clarvi_regfile_sequencer.sv
module tb_clarvi_regfile_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        core_req_valid, core_req_write, dbg_req_valid, dbg_req_write;
    logic [4:0]  core_req_reg, dbg_req_reg;
    logic [63:0] core_req_wdata, dbg_req_wdata;
    logic        core_req_ready, dbg_req_ready;
    logic        resp_valid, resp_source, busy, rf_write_enable;
    logic [63:0] resp_rdata;
    logic [4:0]  rf_fetch_register, rf_write_register;
    logic [1:0]  rf_fetch_part, rf_write_part;
    logic [15:0] rf_data_in, rf_data_out;

    // second instance, debug-priority mode, only its arbitration is observed
    logic        p_core_ready, p_dbg_ready, p_resp_valid, p_resp_source, p_busy, p_we;
    logic [63:0] p_resp_rdata;
    logic [4:0]  p_freg, p_wreg;
    logic [1:0]  p_fpart, p_wpart;
    logic [15:0] p_din;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // register-file model: 64-bit registers accessed 16 bits at a time
    logic [63:0] mem [32];
    assign rf_data_out = mem[rf_fetch_register][{rf_fetch_part, 4'b0000} +: 16];
    always @(posedge clock)
        if (rf_write_enable)
            mem[rf_write_register][{rf_write_part, 4'b0000} +: 16] <= rf_data_in;

    clarvi_regfile_sequencer #(.DBG_PRIORITY(1'b0)) dut (
        .clock(clock), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_write(core_req_write), .core_req_reg(core_req_reg),
        .core_req_wdata(core_req_wdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_reg(dbg_req_reg),
        .dbg_req_wdata(dbg_req_wdata),
        .resp_valid(resp_valid), .resp_source(resp_source), .resp_rdata(resp_rdata),
        .busy(busy),
        .rf_fetch_register(rf_fetch_register), .rf_write_register(rf_write_register),
        .rf_fetch_part(rf_fetch_part), .rf_write_part(rf_write_part),
        .rf_data_in(rf_data_in), .rf_write_enable(rf_write_enable),
        .rf_data_out(rf_data_out)
    );

    clarvi_regfile_sequencer #(.DBG_PRIORITY(1'b1)) dut_pri (
        .clock(clock), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(p_core_ready),
        .core_req_write(core_req_write), .core_req_reg(core_req_reg),
        .core_req_wdata(core_req_wdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(p_dbg_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_reg(dbg_req_reg),
        .dbg_req_wdata(dbg_req_wdata),
        .resp_valid(p_resp_valid), .resp_source(p_resp_source), .resp_rdata(p_resp_rdata),
        .busy(p_busy),
        .rf_fetch_register(p_freg), .rf_write_register(p_wreg),
        .rf_fetch_part(p_fpart), .rf_write_part(p_wpart),
        .rf_data_in(p_din), .rf_write_enable(p_we),
        .rf_data_out(16'h5a5a)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        core_req_valid = 0; core_req_write = 0; core_req_reg = 0; core_req_wdata = 0;
        dbg_req_valid  = 0; dbg_req_write  = 0; dbg_req_reg  = 0; dbg_req_wdata  = 0;
    endtask

    task automatic set_req(input bit src, input bit wr, input logic [4:0] r, input logic [63:0] wd);
        if (src) begin
            dbg_req_valid = 1; dbg_req_write = wr; dbg_req_reg = r; dbg_req_wdata = wd;
        end else begin
            core_req_valid = 1; core_req_write = wr; core_req_reg = r; core_req_wdata = wd;
        end
    endtask

    // waits (bounded) for ready of src; returns at #1 after the accept edge
    task automatic wait_accept(input bit src);
        int n = 0;
        while (!(src ? dbg_req_ready : core_req_ready) && n < 20) begin
            tick(); n++;
        end
        chk("accept_seen", (n < 20), 1'b1);
        tick();
    endtask

    // full transaction with per-part checks and response check
    task automatic run_txn(input bit src, input bit wr, input logic [4:0] r,
                           input logic [63:0] wd, input logic [63:0] exp_rd, input bit exp_we);
        set_req(src, wr, r, wd);
        wait_accept(src);
        // scramble inputs after accept; the latched request must not change
        clear_reqs();
        core_req_wdata = 64'hFFFF_0000_FFFF_0000; core_req_reg = 5'd31;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("part%0d_idx", p), {62'd0, rf_write_part}, p);
            chk($sformatf("part%0d_reg", p), {59'd0, rf_write_register}, r);
            chk($sformatf("part%0d_we", p), rf_write_enable, exp_we);
            if (wr) chk($sformatf("part%0d_din", p), rf_data_in, wd[16*p +: 16]);
            chk($sformatf("part%0d_resp", p), resp_valid, 1'b0);
            tick();
        end
        chk("resp_valid", resp_valid, 1'b1);
        chk("resp_source", resp_source, src);
        chk("resp_rdata", resp_rdata, exp_rd);
        clear_reqs();
        tick();
        chk("resp_pulse_end", resp_valid, 1'b0);
        chk("rdata_idle_zero", resp_rdata, 64'd0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        int n;
        bit order [3];
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        mem[0] = 64'hDEAD_BEEF_0BAD_F00D;   // x0 reads must mask this
        clear_reqs();
        reset = 1;
        set_req(0, 0, 5'd1, 64'd0);
        tick();
        chk("ready_in_reset", {core_req_ready, dbg_req_ready}, 2'b00);
        tick();
        clear_reqs();
        reset = 0;
        tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_resp", {resp_valid, resp_source, rf_write_enable}, 3'b000);
        chk("reset_rf", {rf_fetch_register, rf_fetch_part, rf_data_in}, 23'd0);

        // core write then read of reg 5
        run_txn(0, 1, 5'd5, 64'h1122334455667788, 64'd0, 1);
        run_txn(0, 0, 5'd5, 64'd0, 64'h1122334455667788, 0);
        // debug write/read of x0
        run_txn(1, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        run_txn(1, 0, 5'd0, 64'd0, 64'd0, 0);
        chk("x0_untouched", mem[0], 64'hDEAD_BEEF_0BAD_F00D);

        // request held through busy: accepted exactly 6 cycles after first accept
        set_req(0, 0, 5'd5, 64'd0);
        wait_accept(0);
        n = 0;
        while (!core_req_ready && n < 20) begin
            chk("held_ready_low_busy", busy, 1'b1);
            tick(); n++;
        end
        chk("held_reaccept_cycle", n, 5);   // sampled from T+1: ready first at T+6
        tick();
        clear_reqs();
        for (int i = 0; i < 6; i++) tick();

        // arbitration after reset, both requesters continuously valid
        reset = 1;
        tick();
        reset = 0;
        set_req(0, 0, 5'd1, 64'd0);
        set_req(1, 0, 5'd2, 64'd0);
        #0;
        chk("pri_first_dbg", {p_core_ready, p_dbg_ready}, 2'b01);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!(core_req_ready || dbg_req_ready) && n < 20) begin tick(); n++; end
            chk("arb_accept_seen", (n < 20), 1'b1);
            chk("arb_one_ready", core_req_ready && dbg_req_ready, 1'b0);
            order[k] = dbg_req_ready;
            tick();
        end
        chk("arb_order", {order[0], order[1], order[2]}, 3'b010);
        clear_reqs();
        for (int i = 0; i < 6; i++) tick();

        // reset in the part-2 cycle of a write to reg 7
        set_req(0, 1, 5'd7, 64'hAAAABBBBCCCCDDDD);
        wait_accept(0);
        clear_reqs();
        tick(); tick();
        chk("abort_part2", {62'd0, rf_write_part}, 2);
        reset = 1;
        #1;
        chk("abort_we_now", rf_write_enable, 1'b0);
        tick();
        chk("abort_we_next", rf_write_enable, 1'b0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) n++;
            tick();
        end
        reset = 0;
        chk("abort_no_resp", n, 0);
        chk("abort_mem_low", mem[7][31:0], 32'hCCCCDDDD);
        set_req(0, 0, 5'd7, 64'd0);
        wait_accept(0);
        clear_reqs();
        for (int i = 0; i < 4; i++) tick();
        chk("abort_read_valid", resp_valid, 1'b1);
        chk("abort_read_low", resp_rdata[31:0], 32'hCCCCDDDD);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clarvi_regfile_sequencer.md
CLARVI_REGFILE_SEQUENCER -- requirements
Module: clarvi_regfile_sequencer

Interface
REQ-001 Parameter: DBG_PRIORITY, default 0, 0 = round-robin arbitration, 1 = debug requester always wins.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 core_req_valid / dbg_req_valid  input  1 each  requester has a pending 64-bit access.
REQ-005 core_req_ready / dbg_req_ready  output  1 each  request accepted this cycle when valid&&ready.
REQ-006 core_req_write / dbg_req_write  input  1 each  1 = write, 0 = read.
REQ-007 core_req_reg / dbg_req_reg  input  5 each  target register index.
REQ-008 core_req_wdata / dbg_req_wdata  input  64 each  write data; ignored for reads.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_source  output  1  0 = core, 1 = debug; valid only with resp_valid.
REQ-011 resp_rdata  output  64  read result; 0 for writes.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 rf_fetch_register / rf_write_register  output  5 each  register-file index; both driven from the latched request index.
REQ-014 rf_fetch_part / rf_write_part  output  2 each  16-bit part select, 0 = bits [15:0] ... 3 = bits [63:48].
REQ-015 rf_data_in  output  16  write part data.
REQ-016 rf_write_enable  output  1  register-file write strobe.
REQ-017 rf_data_out  input  16  combinational read data for rf_fetch_register/rf_fetch_part, valid in the same cycle.

Function
REQ-018 States: IDLE, ACCESS, RESP. IDLE->ACCESS on accept; ACCESS->RESP after part counter reaches 3; RESP->IDLE unconditionally.
REQ-019 Ready is asserted only in IDLE, and only to the granted requester; at most one ready is high per cycle.
REQ-020 Grant with one valid requester: that requester. Both valid, DBG_PRIORITY=0: the requester not granted last; DBG_PRIORITY=1: debug.
REQ-021 The last-grant record updates only on accept.
REQ-022 On accept, latch write flag, index, wdata and source; later changes to request inputs have no effect.
REQ-023 ACCESS lasts exactly 4 cycles; a 2-bit part counter runs 0,1,2,3 and drives rf_fetch_part and rf_write_part.
REQ-024 Read: in each ACCESS cycle, capture rf_data_out into bits [16*p+15:16*p] of the result buffer.
REQ-025 Write: rf_write_enable is high in all 4 ACCESS cycles; rf_data_in = wdata[16*p+15:16*p].
REQ-026 Writes to register 0: rf_write_enable stays low throughout; the sequence and response otherwise proceed normally.
REQ-027 Reads of register 0 return 0 regardless of rf_data_out.
REQ-028 Latency: accept in cycle T, parts at T+1..T+4, resp_valid high in T+5 only; next accept possible no earlier than T+6.
REQ-029 resp_rdata holds the assembled value (read) or 0 (write) while resp_valid is high; it is 0 otherwise.
REQ-030 Outside ACCESS: rf_write_enable=0, rf_data_in=0, part=0, rf_fetch_register/rf_write_register=0.
REQ-031 Requesters hold valid and payload stable until accepted; a valid dropped before accept is a legal withdrawal.

Reset
REQ-032 Reset values: state IDLE, part counter 0, last grant = debug (core wins the first contention), result buffer 0, all outputs 0 except ready per REQ-019.
REQ-033 Reset during ACCESS aborts immediately: no further rf_write_enable, no resp_valid. Parts already written stay written (partial 64-bit write is permitted).
REQ-034 While reset is high, both ready outputs are 0.

Verification
REQ-035 Core write reg 5 = 0x1122334455667788 accepted at T -> rf_write_enable high T+1..T+4, rf_data_in 0x7788, 0x5566, 0x3344, 0x1122 with parts 0..3; resp_valid at T+5 with resp_source=0 and resp_rdata=0.
REQ-036 Then core read reg 5 -> resp_rdata=0x1122334455667788 at T+5; rf_write_enable never high.
REQ-037 After reset, core and debug both valid continuously, DBG_PRIORITY=0 -> core served first, debug second, core third; DBG_PRIORITY=1 -> debug served first.
REQ-038 Debug write x0 = all-ones -> rf_write_enable stays 0 and resp_valid is delivered; a subsequent read of x0 -> resp_rdata=0.
REQ-039 Reset asserted in the part-2 cycle of a write of 0xAAAABBBBCCCCDDDD to reg 7 -> rf_write_enable low in the next cycle and no resp_valid; after reset, a read of reg 7 returns low 32 bits 0xCCCCDDDD.
REQ-040 Request held valid during busy -> ready low through ACCESS and RESP; the request is accepted in the first IDLE cycle (T+6).
